// File: rtl/uart_char_tx.sv
// uart_char_tx: buffered 8N1 serial character transmitter.
// A small FIFO absorbs characters from the upstream stage; a two-process
// FSM shifts each one out LSB first as start, 8 data bits and stop.
// Optional feature macro: UART_CHAR_TX_PARITY_EN inserts an even-parity
// bit between the data bits and the stop bit.
module uart_char_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  output logic                          char_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_CHAR_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

`ifdef UART_CHAR_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [7:0]    shift_data;
  logic [7:0]    data_next;
  logic          tx_next;
  logic          busy_next;
  logic          push;
  logic          pop;
  logic          bit_end;

  // Ready depends only on the registered level, so a full FIFO never
  // accepts even when the shifter pops on the same edge.
  assign char_ready = (fifo_level != LEVEL_FULL);
  assign push       = char_valid && char_ready;
  assign bit_end    = (baud == BAUD_LAST);

  // Next-state, pop decision and the registered line value for the next cycle.
  always_comb begin
    state_next = state;
    baud_next  = bit_end ? {BW{1'b0}} : (baud + BW'(1));
    bit_next   = bit_idx;
    data_next  = shift_data;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = {BW{1'b0}};
        if (fifo_level != {LW{1'b0}}) begin
          pop        = 1'b1;
          data_next  = mem[rd_ptr];
          bit_next   = 3'd0;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_CHAR_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          state_next = DATA;
        end
      end
`ifdef UART_CHAR_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end
`endif
      STOP: begin
        // Back-to-back frames: the next character is popped on the last
        // stop-bit cycle so the following start bit has no idle gap.
        if (bit_end) begin
          if (fifo_level != {LW{1'b0}}) begin
            pop        = 1'b1;
            data_next  = mem[rd_ptr];
            bit_next   = 3'd0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = {BW{1'b0}};
      end
    endcase

    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_next[bit_next];
`ifdef UART_CHAR_TX_PARITY_EN
      PARITY:  tx_next = even_parity(data_next);
`endif
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  // FSM, baud/bit counters, frame data and registered line outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      baud       <= {BW{1'b0}};
      bit_idx    <= 3'd0;
      shift_data <= 8'h00;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      baud       <= baud_next;
      bit_idx    <= bit_next;
      shift_data <= data_next;
      tx         <= tx_next;
      busy       <= busy_next;
    end
  end

  // FIFO pointers and level; power-of-two depth makes the pointers wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      fifo_level <= {LW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= char_in;
    end
  end

endmodule

// File: tb/tb_uart_char_tx.sv
// Self-checking bench for uart_char_tx: a queue-based frame model checks
// every cycle, plus table-driven frames and directed corner sequences.
module tb_uart_char_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef UART_CHAR_TX_PARITY_EN
  localparam int NBITS  = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS  = 10;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_CYC = NBITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  uart_char_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Edge counter used to time directed sequences.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  logic [10:0] fbits    = 11'h7FF;
  int          fcyc     = 0;
  bit          active   = 1'b0;
  int          m_pushes = 0;

  function automatic logic [10:0] frame_of(input logic [7:0] ch);
    logic [10:0] f;
    f      = 11'h7FF;
    f[0]   = 1'b0;
    f[8:1] = ch;
    if (PAR_EN) f[9] = ^ch;
    return f;
  endfunction

  task automatic model_step();
    bit acc;
    acc = char_valid && (mq.size() != DEPTH);
    if (active) begin
      fcyc++;
      if (fcyc == FRAME_CYC) active = 1'b0;
    end
    if (!active && mq.size() > 0) begin
      fbits  = frame_of(mq.pop_front());
      fcyc   = 0;
      active = 1'b1;
    end
    if (acc) begin
      mq.push_back(char_in);
      m_pushes++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        active = 1'b0;
        fcyc   = 0;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_tx",    32'(tx),         32'(active ? fbits[fcyc / CLK_DIV] : 1'b1));
        check("cyc_busy",  32'(busy),       32'(active));
        check("cyc_level", 32'(fifo_level), 32'(mq.size()));
        check("cyc_ready", 32'(char_ready), 32'(mq.size() != DEPTH));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    logic [7:0] ch;
    logic       par;
  } vec_t;
  vec_t tbl[6];

  function automatic logic exp_bit(input logic [7:0] ch, input logic par, input int b);
    logic r;
    if (b == 0)                 r = 1'b0;
    else if (b <= 8)            r = ch[b-1];
    else if (b == 9 && PAR_EN)  r = par;
    else                        r = 1'b1;
    return r;
  endfunction

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      if (!active && mq.size() == 0) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] gstr[9];
  int base, idx, rel, first_edge, busy_n;
  bit done;

  initial begin
    tbl[0] = '{8'h47, 1'b0};
    tbl[1] = '{8'h61, 1'b1};
    tbl[2] = '{8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b0};
    tbl[4] = '{8'h80, 1'b1};
    tbl[5] = '{8'hA5, 1'b0};
    gstr = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};

    reset_n    = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx",    32'(tx),         32'd1);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(char_ready), 32'd1);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk);

    // Single frames from the table: exact bit pattern, latency, length.
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      char_in    = tbl[i].ch;
      char_valid = 1'b1;
      @(negedge clk);
      char_valid = 1'b0;
      char_in    = ~tbl[i].ch;
      check("lat_tx",    32'(tx),         32'd1);
      check("lat_level", 32'(fifo_level), 32'd1);
      busy_n = 0;
      for (int c = 0; c < FRAME_CYC; c++) begin
        @(negedge clk);
        char_in = 8'($urandom);
        check("tbl_tx", 32'(tx), 32'(exp_bit(tbl[i].ch, tbl[i].par, c / CLK_DIV)));
        if (busy) busy_n++;
      end
      @(negedge clk);
      check("tbl_end_busy", 32'(busy), 32'd0);
      check("tbl_end_tx",   32'(tx),   32'd1);
      check("tbl_busy_len", 32'(busy_n), 32'(FRAME_CYC));
    end

    // "Guatemala" with valid held: fill, full-FIFO pop, back-to-back frames.
    wait_idle();
    base       = m_pushes;
    char_in    = gstr[0];
    char_valid = 1'b1;
    first_edge = cyc + 1;
    busy_n     = 0;
    done       = 1'b0;
    for (int k = 0; k < 1500 && !done; k++) begin
      @(negedge clk);
      idx = m_pushes - base;
      if (idx < 9) begin
        char_in    = gstr[idx];
        char_valid = 1'b1;
      end else begin
        char_valid = 1'b0;
      end
      rel = cyc - first_edge;
      if (busy) busy_n++;
      if (rel == 4) begin
        check("g_full_level", 32'(fifo_level), 32'd4);
        check("g_full_ready", 32'(char_ready), 32'd0);
      end
      if (rel == FRAME_CYC) check("g_ready_low", 32'(char_ready), 32'd0);
      if (rel == FRAME_CYC + 1) begin
        check("g_pop_ready", 32'(char_ready), 32'd1);
        check("g_pop_level", 32'(fifo_level), 32'd3);
      end
      if (rel == FRAME_CYC + 2) check("g_refill_level", 32'(fifo_level), 32'd4);
      if (rel > 10 && !busy && idx == 9) done = 1'b1;
    end
    char_valid = 1'b0;
    if (!done) check("g_timeout", 32'd0, 32'd1);
    check("g_busy_total", 32'(busy_n), 32'(9 * FRAME_CYC));

    // Reset at cycle 17 of a frame with three characters buffered.
    wait_idle();
    for (int j = 0; j < 4; j++) begin
      char_in    = 8'($urandom);
      char_valid = 1'b1;
      @(negedge clk);
    end
    char_valid = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (active && fcyc == 16) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) check("r_timeout", 32'd0, 32'd1);
    check("r_pre_level", 32'(fifo_level), 32'd3);
    check("r_pre_busy",  32'(busy),       32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("r_tx",    32'(tx),         32'd1);
    check("r_busy",  32'(busy),       32'd0);
    check("r_level", 32'(fifo_level), 32'd0);
    check("r_ready", 32'(char_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    busy_n = 0;
    for (int k = 0; k < 3 * FRAME_CYC; k++) begin
      @(negedge clk);
      if (!tx || busy) busy_n++;
    end
    check("r_quiet_after", 32'(busy_n), 32'd0);

    // Push and pop on the same edge at level 2.
    wait_idle();
    for (int j = 0; j < 3; j++) begin
      char_in    = 8'h30 + 8'(j);
      char_valid = 1'b1;
      @(negedge clk);
    end
    char_valid = 1'b0;
    check("pp_pre_level", 32'(fifo_level), 32'd2);
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (active && fcyc == FRAME_CYC - 1) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) check("pp_timeout", 32'd0, 32'd1);
    char_in    = 8'h33;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    check("pp_level", 32'(fifo_level), 32'd2);
    check("pp_busy",  32'(busy),       32'd1);
    wait_idle();

    // Randomised traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      char_valid = ($urandom_range(0, 2) == 0);
      char_in    = 8'($urandom);
    end
    char_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("end_idle_tx",   32'(tx),   32'd1);
    check("end_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
